instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Decouples instr_fetch from a variable-latency instruction memory.
//  Issues sequential word fetches ahead of the pipeline and queues {pc, instr} pairs.
//  On a branch/jump redirect from decode, discards all wrong-path data.
//  Sits directly upstream of instr_fetch: pf_instr/pf_pc_plus_4 feed the IF/ID register.
// PARAMETERS
//  DEPTH    4             queue entries; also max outstanding+queued words (power of 2, >=2)
//  RESET_PC 32'h0000_0000 first fetch address after reset
// PORTS
//  clk           in  1   clock; all state on rising edge
//  reset         in  1   asynchronous, active-low reset
//  imem_req      out 1   fetch request valid
//  imem_addr     out 32  fetch word address (byte addr, [1:0]=0)
//  imem_gnt      in  1   request accepted this cycle (req & gnt = issue)
//  imem_rvalid   in  1   read data valid; responses return in issue order, latency >=1
//  imem_rdata    in  32  instruction word
//  pf_valid      out 1   head entry valid
//  pf_instr      out 32  head instruction
//  pf_pc_plus_4  out 32  head pc + 4
//  pf_ready      in  1   IF consumes head (driven ~stall_if)
//  redirect      in  1   branch taken or jump in ID (pc_src | jump)
//  redirect_pc   in  32  new fetch target (pc_branch / pc_jump)
//  perf_redirects out 16 redirect count (0 when IPQ_PERF_CNT_EN undefined)
//  perf_starve    out 16 cycles with pf_ready & !pf_valid (0 when macro undefined)
// BEHAVIOUR
//  Reset (reset=0, async): queue empty, inflight=0, fetch_pc=resp_pc=RESET_PC, state=S_BOOT;
//   imem_req=0, imem_addr=RESET_PC, pf_valid=0, pf_instr=0, pf_pc_plus_4=RESET_PC+4, perf_*=0.
//  FSM: S_BOOT -> S_RUN after one cycle (lets imem leave reset).
//   S_RUN: imem_req = !redirect & (count+inflight < DEPTH); imem_addr=fetch_pc.
//    issue: fetch_pc += 4, inflight++. rvalid: push {resp_pc, rdata}, resp_pc += 4, inflight--.
//    redirect & inflight_next>0 -> S_FLUSH; redirect & inflight_next==0 -> stay S_RUN.
//   S_FLUSH: imem_req=0; every rvalid dropped, inflight--; -> S_RUN when inflight reaches 0.
//    redirect in S_FLUSH: retarget fetch_pc/resp_pc, stay.
//  Redirect (any state): queue cleared at next edge; fetch_pc<=resp_pc<=redirect_pc;
//   rvalid and pop in the same cycle are ignored (wrong path); redirect wins over all.
//  Latency: rvalid in cycle N -> pf_valid in N+1 (no bypass). Pop and push same cycle allowed.
//  Credit rule guarantees no overflow: push when full never occurs; assertion on it.
//  pf_valid = count!=0; pop = pf_valid & pf_ready & !redirect. Pointers wrap mod DEPTH.
//  Counters: inflight 0..DEPTH; count 0..DEPTH; PC arithmetic 32-bit modulo wrap.
//  imem_rvalid with inflight==0 is a protocol error: ignored, assertion fires.
// CONFIGURATION
//  IPQ_PERF_CNT_EN defined: perf_redirects increments per redirect cycle, perf_starve per
//   starved cycle; both saturate at 16'hFFFF, cleared by reset.
//  Undefined: counters not built, perf_* tied to 16'd0.
// STRUCTURE
//  mips_pkg: FSM state encodings (S_BOOT/S_RUN/S_FLUSH), PC_INC=4, default RESET_PC.
//  Sub-module ipq_fifo: DEPTH x 64-bit sync FIFO (push, pop, clear, count, head out).
//  Top holds FSM, fetch_pc/resp_pc, inflight credit counter, perf counters.
// TESTING
//  Reset release, imem gnt=1, 1-cycle latency, pf_ready=1 -> addresses 0,4,8..; pf_pc_plus_4 4,8,12.
//  pf_ready=0 held -> exactly DEPTH(4) requests issued, imem_req drops, pf_valid stays 1, no loss.
//  3 words inflight, redirect_pc=0x40 -> S_FLUSH, 3 stale rvalids dropped, next req addr 0x40.
//  redirect with rvalid and pop same cycle -> queue empty next cycle, head later pc 0x40, instr correct.
//  gnt random 50%, latency 1-5 -> instr stream matches memory image in order, no dup/skip.
//  reset asserted mid-flush -> all outputs to reset values immediately; restart at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_queue_pkg.sv
// instr_prefetch_queue_pkg: shared FSM encoding and PC constants for the instruction prefetch queue
package instr_prefetch_queue_pkg;
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_e;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// instr_prefetch_queue_fifo: DEPTH-entry synchronous FIFO holding {pc, instr} pairs, with single-cycle clear
module instr_prefetch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [W-1:0]             i_din,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= i_push ? r_wr + AW'(1) : r_wr;
            r_rd    <= i_pop ? r_rd + AW'(1) : r_rd;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    // storage needs no reset: the head is only observed while count is non-zero
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr] <= i_din;
    end
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_push |-> r_count != (AW+1)'(DEPTH));
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: credit-limited sequential fetch ahead of IF with redirect flush.
// Define IPQ_PERF_CNT_EN to build the saturating redirect/starve performance counters.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_pf_valid,
    output logic [31:0] o_pf_instr,
    output logic [31:0] o_pf_pc_plus_4,
    input  logic        i_pf_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [15:0] o_perf_redirects,
    output logic [15:0] o_perf_starve
);
    localparam int AW = $clog2(DEPTH);
    state_e      r_state, w_state_next;
    logic [31:0] r_fetch_pc, r_resp_pc;
    logic [AW:0] r_inflight, w_inflight_next, w_count;
    logic [63:0] w_head;
    logic        w_issue, w_rv, w_push, w_pop;
    // queued plus outstanding words never exceed DEPTH, so every response has a slot
    assign o_imem_req      = r_state == S_RUN && !i_redirect &&
                             (AW+2)'(w_count) + (AW+2)'(r_inflight) < (AW+2)'(DEPTH);
    assign o_imem_addr     = r_fetch_pc;
    assign w_issue         = o_imem_req && i_imem_gnt;
    assign w_rv            = i_imem_rvalid && r_inflight != '0;
    assign w_inflight_next = r_inflight + (AW+1)'(w_issue) - (AW+1)'(w_rv);
    assign w_push          = w_rv && r_state != S_FLUSH && !i_redirect;
    assign w_pop           = o_pf_valid && i_pf_ready && !i_redirect;
    assign o_pf_valid      = w_count != '0;
    assign o_pf_instr      = o_pf_valid ? w_head[31:0] : '0;
    assign o_pf_pc_plus_4  = (o_pf_valid ? w_head[63:32] : r_resp_pc) + PC_INC;
    instr_prefetch_queue_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (i_redirect),
        .i_din   ({r_resp_pc, i_imem_rdata}),
        .o_head  (w_head),
        .o_count (w_count)
    );
    always_comb begin
        w_state_next = r_state;
        w_state_next = r_state == S_BOOT ? S_RUN :
                       (r_state == S_FLUSH || i_redirect) && w_inflight_next != '0 ? S_FLUSH : S_RUN;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_BOOT;
        else          r_state <= w_state_next;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            r_fetch_pc <= i_redirect ? i_redirect_pc : w_issue ? r_fetch_pc + PC_INC : r_fetch_pc;
            r_resp_pc  <= i_redirect ? i_redirect_pc : w_push ? r_resp_pc + PC_INC : r_resp_pc;
        end
    end
`ifdef IPQ_PERF_CNT_EN
    logic [15:0] r_perf_redirects, r_perf_starve;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_redirects <= '0;
            r_perf_starve    <= '0;
        end else begin
            if (i_redirect && r_perf_redirects != 16'hFFFF) r_perf_redirects <= r_perf_redirects + 16'd1;
            if (i_pf_ready && !o_pf_valid && r_perf_starve != 16'hFFFF) r_perf_starve <= r_perf_starve + 16'd1;
        end
    end
    assign o_perf_redirects = r_perf_redirects;
    assign o_perf_starve    = r_perf_starve;
`else
    assign o_perf_redirects = 16'd0;
    assign o_perf_starve    = 16'd0;
`endif
    a_rvalid_credit: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_imem_rvalid |-> r_inflight != '0);
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed scenarios against an in-order variable-latency memory model
module tb_instr_prefetch_queue;
`ifdef IPQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, pf_ready = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        t_gnt = 1'b0, t_rvalid = 1'b0, a_gnt = 1'b0, a_rvalid = 1'b0;
    logic [31:0] t_rdata = '0, a_rdata = '0;
    logic        m_auto = 1'b0, m_gnt_rand = 1'b0, m_lat_rand = 1'b0;
    int          m_lat = 1;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        o_imem_req, o_pf_valid;
    logic [31:0] o_imem_addr, o_pf_instr, o_pf_pc_plus_4;
    logic [15:0] o_perf_redirects, o_perf_starve;
    int          n_cmp = 0, n_fail = 0, cyc = 0, last_due = 0;
    logic [31:0] issued[$], pend_a[$];
    logic [63:0] pops[$];
    int          pend_t[$], rv_cyc[$], pv_cyc[$];
    logic        prev_pv = 1'b0;

    assign gnt    = m_auto ? a_gnt : t_gnt;
    assign rvalid = m_auto ? a_rvalid : t_rvalid;
    assign rdata  = m_auto ? a_rdata : t_rdata;

    instr_prefetch_queue dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_pf_valid(o_pf_valid), .o_pf_instr(o_pf_instr), .o_pf_pc_plus_4(o_pf_pc_plus_4),
        .i_pf_ready(pf_ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_perf_redirects(o_perf_redirects), .o_perf_starve(o_perf_starve)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC001_D00D;
    endfunction

    // memory model and observer: drives at negedge, samples settled outputs 3ns later
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend_a.delete();
                pend_t.delete();
                last_due = 0;
            end
            a_gnt = m_gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst_n && pend_a.size() > 0 && pend_t[0] <= cyc) begin
                a_rvalid = 1'b1;
                a_rdata  = mem_word(pend_a.pop_front());
                void'(pend_t.pop_front());
            end else begin
                a_rvalid = 1'b0;
                a_rdata  = '0;
            end
            #3;
            if (rst_n) begin
                if (o_imem_req && gnt) begin
                    int due;
                    due = cyc + (m_lat_rand ? int'($urandom_range(1, 5)) : m_lat);
                    if (due <= last_due) due = last_due + 1;
                    issued.push_back(o_imem_addr);
                    pend_a.push_back(o_imem_addr);
                    pend_t.push_back(due);
                    last_due = due;
                end
                if (o_pf_valid && pf_ready && !redirect) pops.push_back({o_pf_pc_plus_4, o_pf_instr});
                if (rvalid) rv_cyc.push_back(cyc);
                if (o_pf_valid && !prev_pv) pv_cyc.push_back(cyc);
            end
            prev_pv = rst_n && o_pf_valid;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; m_auto = 1'b0; redirect = 1'b0; pf_ready = 1'b0;
        t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", o_imem_req); end
        n_cmp++; if (o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", o_imem_addr); end
        n_cmp++; if (o_pf_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_pf_valid); end
        n_cmp++; if (o_pf_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", o_pf_instr); end
        n_cmp++; if (o_pf_pc_plus_4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4: got %h want 4", o_pf_pc_plus_4); end
        n_cmp++; if (o_perf_redirects !== 16'h0 || o_perf_starve !== 16'h0) begin n_fail++; $display("FAIL reset_perf: got %h/%h want 0/0", o_perf_redirects, o_perf_starve); end
    endtask

    task automatic test_sequential();
        int bi, bp, br, bv;
        logic [31:0] a;
        logic [63:0] p;
        do_reset();
        bi = issued.size(); bp = pops.size(); br = rv_cyc.size(); bv = pv_cyc.size();
        pf_ready = 1'b1; m_gnt_rand = 1'b0; m_lat_rand = 1'b0; m_lat = 1; m_auto = 1'b1;
        repeat (15) @(negedge clk);
        #4;
        for (int i = 0; i < 3; i++) begin
            a = issued.size() > bi + i ? issued[bi + i] : 'x;
            n_cmp++; if (a !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, a, 4 * i); end
            p = pops.size() > bp + i ? pops[bp + i] : 'x;
            n_cmp++; if (p !== {32'(4 * i + 4), mem_word(32'(4 * i))}) begin n_fail++; $display("FAIL seq_pop[%0d]: got %h want %h_%h", i, p, 4 * i + 4, mem_word(32'(4 * i))); end
        end
        n_cmp++;
        if (rv_cyc.size() <= br || pv_cyc.size() <= bv || pv_cyc[bv] - rv_cyc[br] != 1) begin
            n_fail++; $display("FAIL seq_latency: rvalid-to-valid cycles not 1 (rv=%0d pv=%0d)", rv_cyc.size() > br ? rv_cyc[br] : -1, pv_cyc.size() > bv ? pv_cyc[bv] : -1);
        end
    endtask

    task automatic test_backpressure();
        int bi, bp;
        logic [63:0] p;
        do_reset();
        bi = issued.size(); bp = pops.size();
        pf_ready = 1'b0; m_gnt_rand = 1'b0; m_lat_rand = 1'b0; m_lat = 2; m_auto = 1'b1;
        repeat (20) @(negedge clk);
        #4;
        n_cmp++; if (issued.size() - bi != 4) begin n_fail++; $display("FAIL bp_issues: got %0d want 4", issued.size() - bi); end
        n_cmp++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b want 0", o_imem_req); end
        n_cmp++; if (o_pf_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", o_pf_valid); end
        n_cmp++; if (o_pf_pc_plus_4 !== 32'h4 || o_pf_instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL bp_head: got %h/%h want 4/%h", o_pf_pc_plus_4, o_pf_instr, mem_word(32'h0)); end
        @(negedge clk);
        pf_ready = 1'b1;
        repeat (25) @(negedge clk);
        #4;
        for (int i = 0; i < 8; i++) begin
            p = pops.size() > bp + i ? pops[bp + i] : 'x;
            n_cmp++; if (p !== {32'(4 * i + 4), mem_word(32'(4 * i))}) begin n_fail++; $display("FAIL bp_pop[%0d]: got %h want %h_%h", i, p, 4 * i + 4, mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_flush();
        int bi;
        do_reset();
        bi = issued.size();
        pf_ready = 1'b1; t_gnt = 1'b1;
        for (int k = 0; k < 50 && issued.size() - bi < 3; k++) begin @(negedge clk); #4; end
        n_cmp++; if (issued.size() - bi != 3) begin n_fail++; $display("FAIL flush_setup: got %0d issues want 3", issued.size() - bi); end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        n_cmp++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req_redirect: got %b want 0", o_imem_req); end
        @(negedge clk);
        redirect = 1'b0; t_rvalid = 1'b1; t_rdata = 32'hBAD0_0000;
        #1;
        n_cmp++; if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h40) begin n_fail++; $display("FAIL flush_hold: got req %b addr %h want 0/40", o_imem_req, o_imem_addr); end
        @(negedge clk);
        t_rdata = 32'hBAD0_0001;
        #1;
        n_cmp++; if (o_imem_req !== 1'b0 || o_pf_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop1: got req %b valid %b want 0/0", o_imem_req, o_pf_valid); end
        @(negedge clk);
        t_rdata = 32'hBAD0_0002;
        #1;
        n_cmp++; if (o_imem_req !== 1'b0 || o_pf_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop2: got req %b valid %b want 0/0", o_imem_req, o_pf_valid); end
        @(negedge clk);
        t_rvalid = 1'b0;
        #1;
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h40 || o_pf_valid !== 1'b0) begin n_fail++; $display("FAIL flush_resume: got req %b addr %h valid %b want 1/40/0", o_imem_req, o_imem_addr, o_pf_valid); end
        @(negedge clk);
        t_gnt = 1'b0; t_rvalid = 1'b1; t_rdata = mem_word(32'h40);
        @(negedge clk);
        t_rvalid = 1'b0;
        #1;
        n_cmp++; if (o_pf_valid !== 1'b1 || o_pf_pc_plus_4 !== 32'h44 || o_pf_instr !== mem_word(32'h40)) begin n_fail++; $display("FAIL flush_newpath: got %b/%h/%h want 1/44/%h", o_pf_valid, o_pf_pc_plus_4, o_pf_instr, mem_word(32'h40)); end
    endtask

    task automatic test_collision();
        int bi;
        do_reset();
        bi = issued.size();
        t_gnt = 1'b1;
        for (int k = 0; k < 50 && issued.size() - bi < 2; k++) begin @(negedge clk); #4; end
        @(negedge clk);
        t_gnt = 1'b0; t_rvalid = 1'b1; t_rdata = mem_word(32'h0);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h40; t_rdata = mem_word(32'h4); pf_ready = 1'b1;
        #1;
        n_cmp++; if (o_pf_valid !== 1'b1) begin n_fail++; $display("FAIL coll_pre_valid: got %b want 1", o_pf_valid); end
        @(negedge clk);
        redirect = 1'b0; t_rvalid = 1'b0; t_gnt = 1'b1;
        #1;
        n_cmp++; if (o_pf_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h40) begin n_fail++; $display("FAIL coll_cleared: got valid %b req %b addr %h want 0/1/40", o_pf_valid, o_imem_req, o_imem_addr); end
        @(negedge clk);
        t_gnt = 1'b0; t_rvalid = 1'b1; t_rdata = mem_word(32'h40);
        @(negedge clk);
        t_rvalid = 1'b0;
        #1;
        n_cmp++; if (o_pf_valid !== 1'b1 || o_pf_pc_plus_4 !== 32'h44 || o_pf_instr !== mem_word(32'h40)) begin n_fail++; $display("FAIL coll_head: got %b/%h/%h want 1/44/%h", o_pf_valid, o_pf_pc_plus_4, o_pf_instr, mem_word(32'h40)); end
        n_cmp++; if (o_perf_redirects !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL perf_redirects: got %0d want %0d", o_perf_redirects, PERF ? 1 : 0); end
        n_cmp++; if (o_perf_starve !== (PERF ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL perf_starve: got %0d want %0d", o_perf_starve, PERF ? 2 : 0); end
    endtask

    task automatic test_random_stream();
        int bp;
        logic [63:0] p;
        do_reset();
        bp = pops.size();
        m_gnt_rand = 1'b1; m_lat_rand = 1'b1; m_auto = 1'b1;
        for (int k = 0; k < 3000 && pops.size() - bp < 40; k++) begin
            @(negedge clk);
            pf_ready = $urandom_range(0, 3) != 0;
        end
        #4;
        n_cmp++; if (pops.size() - bp < 40) begin n_fail++; $display("FAIL rand_budget: got %0d pops want 40", pops.size() - bp); end
        for (int i = 0; i < 40; i++) begin
            p = pops.size() > bp + i ? pops[bp + i] : 'x;
            n_cmp++; if (p !== {32'(4 * i + 4), mem_word(32'(4 * i))}) begin n_fail++; $display("FAIL rand_pop[%0d]: got %h want %h_%h", i, p, 4 * i + 4, mem_word(32'(4 * i))); end
        end
        m_gnt_rand = 1'b0; m_lat_rand = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        int bi, bp;
        logic [31:0] a;
        logic [63:0] p;
        do_reset();
        bi = issued.size();
        m_lat = 5; m_auto = 1'b1;
        for (int k = 0; k < 50 && issued.size() - bi < 3; k++) begin @(negedge clk); #4; end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_cmp++; if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h80) begin n_fail++; $display("FAIL mid_flush_state: got req %b addr %h want 0/80", o_imem_req, o_imem_addr); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_reset_fetch: got req %b addr %h want 0/0", o_imem_req, o_imem_addr); end
        n_cmp++; if (o_pf_valid !== 1'b0 || o_pf_instr !== 32'h0 || o_pf_pc_plus_4 !== 32'h4) begin n_fail++; $display("FAIL mid_reset_head: got %b/%h/%h want 0/0/4", o_pf_valid, o_pf_instr, o_pf_pc_plus_4); end
        repeat (2) @(negedge clk);
        bi = issued.size(); bp = pops.size();
        rst_n = 1'b1; pf_ready = 1'b1;
        repeat (20) @(negedge clk);
        #4;
        a = issued.size() > bi ? issued[bi] : 'x;
        n_cmp++; if (a !== 32'h0) begin n_fail++; $display("FAIL restart_addr: got %h want 0", a); end
        p = pops.size() > bp ? pops[bp] : 'x;
        n_cmp++; if (p !== {32'h4, mem_word(32'h0)}) begin n_fail++; $display("FAIL restart_pop: got %h want 4_%h", p, mem_word(32'h0)); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_flush();
        test_collision();
        test_random_stream();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
